// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/response, redirect, decode handoff.
interface instr_fetch_if;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;

  // Fetch-stage side
  modport master (
    input  fetch_en, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc
  );

  // Environment side: memory, execute and decode
  modport slave (
    output fetch_en, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// RV64 instruction fetch: PC, credit-limited in-order requests, instruction queue,
// redirect flush with discard of responses still owed by memory.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [CNT_W-1:0] q_count_q, q_count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [PTR_W-1:0] pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;

  logic [31:0] q_instr_q [QDEPTH];
  logic [63:0] q_pc_q    [QDEPTH];
  logic [63:0] pf_q      [QDEPTH];

  logic [SUM_W-1:0] credits_c;
  logic             req_valid_c;
  logic             req_fire_c;
  logic             if_valid_c;
  logic             pop_c;
  logic             rsp_keep_c;
  logic             rsp_drop_c;

  // Handshake qualifiers; redirect suppresses both request and decode handoff
  always_comb begin
    credits_c   = SUM_W'(q_count_q) + SUM_W'(inflight_q);
    req_valid_c = (state_q == ST_RUN) && !bus.redirect_valid &&
                  (credits_c < SUM_W'(QDEPTH));
    req_fire_c  = req_valid_c && bus.imem_req_ready;
    if_valid_c  = (q_count_q != '0) && !bus.redirect_valid;
    pop_c       = if_valid_c && bus.if_ready;
    rsp_drop_c  = bus.imem_rsp_valid && (drop_cnt_q != '0);
    rsp_keep_c  = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
  end

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_c;
  assign bus.if_instr       = q_instr_q[q_rd_q];
  assign bus.if_pc          = q_pc_q[q_rd_q];

  // Next-state: FSM, PC, credit counters and queue pointers
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    q_count_d  = q_count_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    q_wr_d     = q_wr_q;
    q_rd_d     = q_rd_q;
    pf_wr_d    = pf_wr_q;
    pf_rd_d    = pf_rd_q;

    if (bus.redirect_valid) begin
      // Every response still owed belongs to the squashed path
      pc_d       = bus.redirect_pc & ~64'h3;
      q_count_d  = '0;
      q_wr_d     = '0;
      q_rd_d     = '0;
      pf_wr_d    = '0;
      pf_rd_d    = '0;
      inflight_d = inflight_q - CNT_W'(bus.imem_rsp_valid);
      drop_cnt_d = inflight_q - CNT_W'(bus.imem_rsp_valid);
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.fetch_en) state_d = ST_RUN;
        ST_RUN:   if (!bus.fetch_en) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (bus.fetch_en)            state_d = ST_RUN;
          else if (inflight_q == '0)   state_d = ST_IDLE;
        end
        default:  state_d = ST_IDLE;
      endcase

      if (req_fire_c) begin
        pc_d    = pc_q + 64'd4;
        pf_wr_d = pf_wr_q + PTR_W'(1);
      end
      inflight_d = inflight_q + CNT_W'(req_fire_c) - CNT_W'(bus.imem_rsp_valid);
      if (rsp_drop_c) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (rsp_keep_c) begin
        q_wr_d  = q_wr_q + PTR_W'(1);
        pf_rd_d = pf_rd_q + PTR_W'(1);
      end
      if (pop_c) q_rd_d = q_rd_q + PTR_W'(1);
      q_count_d = q_count_q + CNT_W'(rsp_keep_c) - CNT_W'(pop_c);
    end
  end

  // State, counters and queue storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      q_count_q  <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      pf_wr_q    <= '0;
      pf_rd_q    <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
        pf_q[i]      <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      q_count_q  <= q_count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
      pf_wr_q    <= pf_wr_d;
      pf_rd_q    <= pf_rd_d;
      if (rsp_keep_c) begin
        q_instr_q[q_wr_q] <= bus.imem_rsp_data;
        q_pc_q[q_wr_q]    <= pf_q[pf_rd_q];
      end
      if (req_fire_c) pf_q[pf_wr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: bus-level memory model plus decode scoreboard, directed phases.
module tb_instr_fetch;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus1 ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(64'h0), .QDEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  instr_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .QDEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       mq [$];
  exp_t        sb [$];
  logic [63:0] acc2 [$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int lat     = 1;

  logic [63:0] model_pc = 64'h0;
  int          acc_count, deliv_count;
  int          first_acc_cyc, first_ifv_cyc;
  int          redir_cyc, first_acc_after_redir_cyc;
  logic [63:0] last_acc_addr, first_addr_after_redir, first_pc_after_redir;
  logic        wait_del;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return 32'(a ^ (a >> 32)) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory model (in order, per-request latency) and decode-side scoreboard
  initial begin
    bus1.imem_rsp_valid = 1'b0;
    bus1.imem_rsp_data  = 32'h0;
    bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        bus1.imem_rsp_valid = 1'b1;
        bus1.imem_rsp_data  = word_of(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus1.imem_rsp_valid = 1'b0;
        bus1.imem_rsp_data  = 32'h0;
      end
      #4;
      if (!rst_n) begin
        mq.delete();
        sb.delete();
        acc2.delete();
        bus1.imem_rsp_valid = 1'b0;
        model_pc = 64'h0;
        acc_count = 0; deliv_count = 0;
        first_acc_cyc = -1; first_ifv_cyc = -1;
        redir_cyc = -1; first_acc_after_redir_cyc = -1;
        first_addr_after_redir = '1; first_pc_after_redir = '1;
        last_acc_addr = '1; wait_del = 1'b0;
      end else begin
        if (bus2.imem_req_valid && bus2.imem_req_ready) acc2.push_back(bus2.imem_req_addr);
        if (bus1.redirect_valid) begin
          chk("req_valid_in_redirect", 64'(bus1.imem_req_valid), 64'd0);
          chk("if_valid_in_redirect", 64'(bus1.if_valid), 64'd0);
          sb.delete();
          model_pc = bus1.redirect_pc & ~64'h3;
          redir_cyc = cyc;
          first_acc_after_redir_cyc = -1;
          first_addr_after_redir = '1;
          first_pc_after_redir = '1;
          wait_del = 1'b1;
        end else begin
          if (bus1.if_valid && first_ifv_cyc < 0) first_ifv_cyc = cyc;
          if (bus1.if_valid && bus1.if_ready) begin
            chk("delivery_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
              exp_t e;
              e = sb.pop_front();
              chk("if_pc", bus1.if_pc, e.pc);
              chk("if_instr", 64'(bus1.if_instr), 64'(e.instr));
            end
            deliv_count++;
            if (wait_del) begin
              first_pc_after_redir = bus1.if_pc;
              wait_del = 1'b0;
            end
          end
          if (bus1.imem_req_valid && bus1.imem_req_ready) begin
            chk("req_addr", bus1.imem_req_addr, model_pc);
            sb.push_back('{model_pc, word_of(model_pc)});
            mq.push_back('{bus1.imem_req_addr, cyc + lat});
            model_pc = model_pc + 64'd4;
            acc_count++;
            last_acc_addr = bus1.imem_req_addr;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            if (redir_cyc >= 0 && first_acc_after_redir_cyc < 0) begin
              first_acc_after_redir_cyc = cyc;
              first_addr_after_redir = bus1.imem_req_addr;
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus1.fetch_en = 1'b0; bus1.imem_req_ready = 1'b1; bus1.redirect_valid = 1'b0;
    bus1.redirect_pc = 64'h0; bus1.if_ready = 1'b1;
    lat = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (acc_count >= n) break;
      @(negedge clk);
    end
    chk(tag, 64'(acc_count >= n), 64'd1);
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc = pc;
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
  endtask

  // Directed sequence
  initial begin
    int d0;
    rst_n = 1'b0;
    bus1.fetch_en = 1'b0; bus1.imem_req_ready = 1'b1; bus1.redirect_valid = 1'b0;
    bus1.redirect_pc = 64'h0; bus1.if_ready = 1'b1;
    bus2.fetch_en = 1'b0; bus2.imem_req_ready = 1'b1; bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = 64'h0; bus2.if_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 64'(bus1.imem_req_valid), 64'd0);
    chk("rst_if_valid", 64'(bus1.if_valid), 64'd0);
    chk("rst_if_instr", 64'(bus1.if_instr), 64'd0);
    chk("rst_if_pc", bus1.if_pc, 64'd0);
    chk("rst_req_addr", bus1.imem_req_addr, 64'd0);
    chk("rst2_req_addr", bus2.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch with 1-cycle memory
    bus1.fetch_en = 1'b1;
    bus2.fetch_en = 1'b1;
    repeat (12) @(negedge clk);
    chk("first_accept_seen", 64'(first_acc_cyc >= 0), 64'd1);
    chk("first_ifvalid_latency", 64'(first_ifv_cyc - first_acc_cyc), 64'd2);
    d0 = deliv_count;
    repeat (10) @(negedge clk);
    chk("throughput_10cyc", 64'(deliv_count - d0), 64'd10);

    // PC wrap on the second instance (no responses, so exactly QDEPTH requests)
    chk("wrap_req_count", 64'(acc2.size()), 64'd4);
    if (acc2.size() == 4) begin
      chk("wrap_addr0", acc2[0], 64'hFFFF_FFFF_FFFF_FFF8);
      chk("wrap_addr1", acc2[1], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_addr2", acc2[2], 64'h0);
      chk("wrap_addr3", acc2[3], 64'h4);
    end
    chk("wrap_req_valid_off", 64'(bus2.imem_req_valid), 64'd0);
    bus2.fetch_en = 1'b0;

    // Random backpressure, latency and occasional redirects
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      bus1.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus1.if_ready = ($urandom_range(0, 2) != 0);
      lat = int'($urandom_range(1, 3));
      if ($urandom_range(0, 24) == 0) begin
        bus1.redirect_valid = 1'b1;
        bus1.redirect_pc = {$urandom(), $urandom()};
      end else begin
        bus1.redirect_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus1.redirect_valid = 1'b0; bus1.imem_req_ready = 1'b1; bus1.if_ready = 1'b1;
    repeat (10) @(negedge clk);
    bus1.fetch_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("random_all_delivered", 64'(sb.size()), 64'd0);
    chk("random_idle", 64'(dut1.state_q), 64'd0);
    chk("random_if_valid_off", 64'(bus1.if_valid), 64'd0);

    // Decode stalled: credits cap outstanding work at QDEPTH
    do_reset();
    bus1.if_ready = 1'b0;
    bus1.fetch_en = 1'b1;
    repeat (12) @(negedge clk);
    chk("stall_accepts", 64'(acc_count), 64'd4);
    chk("stall_req_valid", 64'(bus1.imem_req_valid), 64'd0);
    chk("stall_head_pc", bus1.if_pc, 64'h0);
    bus1.if_ready = 1'b1;
    wait_acc("stall_resume_timeout", 5, 20);
    chk("stall_resume_addr", last_acc_addr, 64'h10);
    repeat (10) @(negedge clk);
    chk("stall_drained_in_order", 64'(deliv_count >= 4), 64'd1);

    // Redirect with 3 in flight, none returning in the redirect cycle
    do_reset();
    lat = 4;
    bus1.fetch_en = 1'b1;
    wait_acc("redir3_timeout", 3, 20);
    bus1.imem_req_ready = 1'b0;
    do_redirect(64'h1002);
    bus1.imem_req_ready = 1'b1;
    chk("redir3_drop_cnt", 64'(dut1.drop_cnt_q), 64'd3);
    repeat (20) @(negedge clk);
    chk("redir3_next_req_cycle", 64'(first_acc_after_redir_cyc - redir_cyc), 64'd1);
    chk("redir3_next_req_addr", first_addr_after_redir, 64'h1000);
    chk("redir3_first_if_pc", first_pc_after_redir, 64'h1000);

    // Redirect coinciding with a response
    do_reset();
    lat = 3;
    bus1.fetch_en = 1'b1;
    wait_acc("redirrsp_timeout", 3, 20);
    do_redirect(64'h2000);
    chk("redirrsp_drop_cnt", 64'(dut1.drop_cnt_q), 64'd2);
    repeat (20) @(negedge clk);
    chk("redirrsp_first_if_pc", first_pc_after_redir, 64'h2000);

    // Back-to-back redirects: second wins
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc = 64'h3000;
    @(negedge clk);
    bus1.redirect_pc = 64'h4000;
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("b2b_next_req_cycle", 64'(first_acc_after_redir_cyc - redir_cyc), 64'd1);
    chk("b2b_next_req_addr", first_addr_after_redir, 64'h4000);
    chk("b2b_first_if_pc", first_pc_after_redir, 64'h4000);

    // fetch_en dropped with 2 in flight
    do_reset();
    lat = 3;
    bus1.fetch_en = 1'b1;
    wait_acc("drain_timeout", 2, 20);
    bus1.fetch_en = 1'b0;
    bus1.imem_req_ready = 1'b0;
    @(negedge clk);
    bus1.imem_req_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain_no_new_req", 64'(acc_count), 64'd2);
    chk("drain_delivered", 64'(deliv_count), 64'd2);
    chk("drain_idle", 64'(dut1.state_q), 64'd0);
    bus1.fetch_en = 1'b1;
    wait_acc("drain_resume_timeout", 3, 20);
    chk("drain_resume_addr", last_acc_addr, 64'h8);
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global bound on run time
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
